// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC / IF-ID sequencing controller for the RV32I core.
//
// Holds the fetch pipe when instruction memory is not ready or a load-use
// hazard is flagged. Parks in RESOLVE after a control op reaches decode,
// waits BR_LAT cycles, then waits for the branch-resolved handshake
// (br_valid) before redirecting the PC.
//
// Optional build macro: PC_FETCH_PERF_EN enables the stall_cycles
// performance counter. When it is undefined, stall_cycles is tied to zero.
//
// Parameters:
//   BR_LAT    : cycles from control-op detect to earliest redirect (1..15)
//   RESET_SRC : pc_src code driven while RESET is high
// Ports:
//   CLK, RESET       : clock (rising edge), async active-high reset
//   OP               : opcode of the instruction in decode
//   imem_ready       : fetch data valid this cycle
//   stall_req        : load-use hazard, hold PC and decode
//   br_valid/b_taken : branch outcome handshake
//   pc_en/pc_src     : PC write enable and next-PC select
//   if_id_en/bubble  : IF/ID load enable and NOP injection
//   busy             : high while resolving a control op
//   stall_cycles     : cycles with pc_en low (perf counter)
module pc_fetch_ctrl #(
  parameter int unsigned BR_LAT    = 1,
  parameter logic [1:0]  RESET_SRC = 2'd2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  OP,
  input  logic        imem_ready,
  input  logic        stall_req,
  input  logic        br_valid,
  input  logic        b_taken,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        if_id_en,
  output logic        bubble,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_RESOLVE = 1'b1;

  // Detect cycle counts as the first wait cycle, hence the minus one.
  localparam logic [3:0] CNT_INIT  = 4'(BR_LAT - 1);

  logic [0:0] state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       jump_flag, jump_flag_nx;
  logic       is_jump, is_ctrl;

  assign is_jump = (OP == OP_JAL) || (OP == OP_JALR);
  assign is_ctrl = is_jump || (OP == OP_BRANCH);

  always_comb begin
    pc_en        = 1'b0;
    pc_src       = 2'd0;
    if_id_en     = 1'b1;
    bubble       = 1'b1;
    busy         = 1'b0;
    state_nx     = state;
    cnt_nx       = cnt;
    jump_flag_nx = jump_flag;
    if (RESET) begin
      // Reset overrides everything so the reset-vector leg is loaded.
      pc_en  = 1'b1;
      pc_src = RESET_SRC;
    end else if (state == S_RUN) begin
      if (!imem_ready) begin
        // Memory not ready wins over a load-use stall: inject a NOP.
      end else if (stall_req) begin
        if_id_en = 1'b0;
        bubble   = 1'b0;
      end else if (is_ctrl) begin
        cnt_nx       = CNT_INIT;
        jump_flag_nx = is_jump;
        state_nx     = S_RESOLVE;
      end else begin
        pc_en  = 1'b1;
        bubble = 1'b0;
      end
    end else begin
      busy = 1'b1;
      // br_valid is only consumed once the latency window has elapsed;
      // memory readiness and stalls do not block the redirect.
      if (cnt != 4'd0) begin
        cnt_nx = cnt - 4'd1;
      end else if (br_valid) begin
        pc_en    = 1'b1;
        pc_src   = (jump_flag | b_taken) ? 2'd1 : 2'd0;
        state_nx = S_RUN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= S_RUN;
      cnt       <= 4'd0;
      jump_flag <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      jump_flag <= jump_flag_nx;
    end
  end

`ifdef PC_FETCH_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      stall_q <= 32'd0;
    else if (!pc_en && (stall_q != 32'hFFFF_FFFF))
      stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl. Two instances share the stimulus:
// u3 (BR_LAT=3) and u1 (BR_LAT=1). Expected output vectors are queued as
// stimulus is applied and popped at the following falling edge.
module tb_pc_fetch_ctrl;

  localparam logic [6:0] ALU  = 7'b0110011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  // Expected {pc_en, pc_src[1:0], if_id_en, bubble, busy}
  localparam logic [5:0] E_RST  = 6'b1_10_110;
  localparam logic [5:0] E_RUN  = 6'b1_00_100;
  localparam logic [5:0] E_DET  = 6'b0_00_110; // detect cycle or imem not ready
  localparam logic [5:0] E_RES  = 6'b0_00_111; // resolving, PC held
  localparam logic [5:0] E_TK   = 6'b1_01_111; // redirect to target
  localparam logic [5:0] E_NT   = 6'b1_00_111; // exit, fall through
  localparam logic [5:0] E_HOLD = 6'b0_00_000; // load-use hold

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic       imem;
    logic       stall;
    logic       brv;
    logic       bt;
    logic [5:0] exp;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [6:0]  OP = ALU;
  logic        imem_ready = 1'b1;
  logic        stall_req = 1'b0;
  logic        br_valid = 1'b0;
  logic        b_taken = 1'b0;

  logic        pc_en3, if_id_en3, bubble3, busy3;
  logic [1:0]  pc_src3;
  logic [31:0] stall3;
  logic        pc_en1, if_id_en1, bubble1, busy1;
  logic [1:0]  pc_src1;
  logic [31:0] stall1;

  logic [5:0] o3, o1;
  assign o3 = {pc_en3, pc_src3, if_id_en3, bubble3, busy3};
  assign o1 = {pc_en1, pc_src1, if_id_en1, bubble1, busy1};

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];

  always #5 CLK = ~CLK;

  pc_fetch_ctrl #(.BR_LAT(3), .RESET_SRC(2'd2)) u3 (
    .CLK(CLK), .RESET(RESET), .OP(OP), .imem_ready(imem_ready),
    .stall_req(stall_req), .br_valid(br_valid), .b_taken(b_taken),
    .pc_en(pc_en3), .pc_src(pc_src3), .if_id_en(if_id_en3),
    .bubble(bubble3), .busy(busy3), .stall_cycles(stall3)
  );

  pc_fetch_ctrl #(.BR_LAT(1), .RESET_SRC(2'd2)) u1 (
    .CLK(CLK), .RESET(RESET), .OP(OP), .imem_ready(imem_ready),
    .stall_req(stall_req), .br_valid(br_valid), .b_taken(b_taken),
    .pc_en(pc_en1), .pc_src(pc_src1), .if_id_en(if_id_en1),
    .bubble(bubble1), .busy(busy1), .stall_cycles(stall1)
  );

  // Apply one cycle of stimulus just after the rising edge and queue its
  // expected outputs.
  task automatic drive(input vec_t v);
    @(posedge CLK);
    #1;
    RESET      = v.rst;
    OP         = v.op;
    imem_ready = v.imem;
    stall_req  = v.stall;
    br_valid   = v.brv;
    b_taken    = v.bt;
    exp_q.push_back(v.exp);
  endtask

  task automatic test_reset();
    vec_t v[5];
    logic [5:0] e;
    v[0] = '{1'b1, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RST};
    v[1] = '{1'b1, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RST};
    v[2] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    v[3] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    v[4] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks += 2;
      if (o3 !== e) begin
        errors++;
        $display("FAIL reset u3 cyc %0d got %b exp %b", i, o3, e);
      end
      if (o1 !== e) begin
        errors++;
        $display("FAIL reset u1 cyc %0d got %b exp %b", i, o1, e);
      end
      if (i == 1) begin
        checks++;
        if (stall3 !== 32'd0) begin
          errors++;
          $display("FAIL reset_stall_cycles got %0d exp 0", stall3);
        end
      end
    end
  endtask

  task automatic test_branch_lat3();
    vec_t v[7];
    logic [5:0] e;
    v[0] = '{1'b1, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RST};
    v[1] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    v[2] = '{1'b0, BR,  1'b1, 1'b0, 1'b0, 1'b0, E_DET};
    v[3] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RES};
    v[4] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RES};
    v[5] = '{1'b0, ALU, 1'b1, 1'b0, 1'b1, 1'b1, E_TK};
    v[6] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (o3 !== e) begin
        errors++;
        $display("FAIL branch_lat3 cyc %0d got %b exp %b", i, o3, e);
      end
    end
  endtask

  task automatic test_jump_forced();
    vec_t v[8];
    logic [5:0] e;
    v[0] = '{1'b1, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RST};
    v[1] = '{1'b0, JAL, 1'b1, 1'b0, 1'b0, 1'b0, E_DET};
    v[2] = '{1'b0, ALU, 1'b1, 1'b0, 1'b1, 1'b0, E_TK};
    v[3] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    v[4] = '{1'b0, BR,  1'b1, 1'b0, 1'b0, 1'b0, E_DET};
    v[5] = '{1'b0, ALU, 1'b1, 1'b0, 1'b1, 1'b0, E_NT};
    v[6] = '{1'b0, BR,  1'b1, 1'b0, 1'b0, 1'b0, E_DET};
    v[7] = '{1'b0, ALU, 1'b0, 1'b1, 1'b1, 1'b1, E_TK}; // redirect ignores imem/stall
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL jump_forced cyc %0d got %b exp %b", i, o1, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[6];
    logic [5:0] e;
    v[0] = '{1'b1, ALU,  1'b1, 1'b0, 1'b0, 1'b0, E_RST};
    v[1] = '{1'b0, JALR, 1'b1, 1'b0, 1'b0, 1'b0, E_DET};
    v[2] = '{1'b0, JALR, 1'b1, 1'b0, 1'b1, 1'b0, E_TK};
    v[3] = '{1'b0, BR,   1'b1, 1'b0, 1'b0, 1'b0, E_DET};
    v[4] = '{1'b0, ALU,  1'b1, 1'b0, 1'b1, 1'b0, E_NT};
    v[5] = '{1'b0, ALU,  1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %b exp %b", i, o1, e);
      end
    end
  endtask

  task automatic test_stall_priority();
    vec_t v[5];
    logic [5:0] e;
    v[0] = '{1'b1, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RST};
    v[1] = '{1'b0, ALU, 1'b0, 1'b1, 1'b0, 1'b0, E_DET};
    v[2] = '{1'b0, BR,  1'b1, 1'b1, 1'b0, 1'b0, E_HOLD};
    v[3] = '{1'b0, ALU, 1'b1, 1'b1, 1'b0, 1'b0, E_HOLD};
    v[4] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (o3 !== e) begin
        errors++;
        $display("FAIL stall_priority cyc %0d got %b exp %b", i, o3, e);
      end
    end
  endtask

  task automatic test_resolve_wait_reset();
    vec_t v[13];
    logic [5:0] e;
    v[0]  = '{1'b1, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RST};
    v[1]  = '{1'b0, BR,  1'b1, 1'b0, 1'b0, 1'b0, E_DET};
    v[2]  = '{1'b0, ALU, 1'b1, 1'b0, 1'b1, 1'b1, E_RES}; // early br_valid ignored
    v[3]  = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RES};
    for (int k = 4; k < 10; k++)
      v[k] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RES};
    v[10] = '{1'b1, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RST};
    v[11] = '{1'b0, ALU, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
    v[12] = '{1'b0, ALU, 1'b1, 1'b0, 1'b1, 1'b1, E_RUN};
    foreach (v[i]) begin
      drive(v[i]);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (o3 !== e) begin
        errors++;
        $display("FAIL resolve_wait cyc %0d got %b exp %b", i, o3, e);
      end
    end
  endtask

  task automatic test_perf();
    logic [31:0] exp_cnt;
`ifdef PC_FETCH_PERF_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    @(posedge CLK); #1;
    RESET = 1'b1; OP = ALU; imem_ready = 1'b1; stall_req = 1'b0;
    br_valid = 1'b0; b_taken = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0; imem_ready = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    imem_ready = 1'b1;
    @(negedge CLK);
    checks += 2;
    if (stall3 !== exp_cnt) begin
      errors++;
      $display("FAIL perf u3 got %0d exp %0d", stall3, exp_cnt);
    end
    if (stall1 !== exp_cnt) begin
      errors++;
      $display("FAIL perf u1 got %0d exp %0d", stall1, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_branch_lat3();
    test_jump_forced();
    test_back_to_back();
    test_stall_priority();
    test_resolve_wait_reset();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
